// File: rtl/tdm_demux4.sv
// Four-lane TDM receive demultiplexer: frame alignment on sync, slot deserialisation, atomic lane update.
// Optional even-parity fifth slot enabled by defining TDM_DEMUX4_PARITY_EN.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] op0,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] op3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
    output logic             par_err
);

`ifdef TDM_DEMUX4_PARITY_EN
    localparam int N = 5;
`else
    localparam int N = 4;
`endif
    // Every slot before the last one is held in a shadow register.
    localparam int NSH = N - 1;
    localparam logic [2:0] LAST = 3'(N - 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t           state;
    logic [2:0]       slot;
    logic [WIDTH-1:0] shadow [0:NSH-1];

`ifdef TDM_DEMUX4_PARITY_EN
    logic par_ok;
    always_comb begin
        par_ok = ((^shadow[0]) ^ (^shadow[1]) ^ (^shadow[2]) ^ (^shadow[3])) == din[0];
    end
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= '0;
            op0         <= '0;
            op1         <= '0;
            op2         <= '0;
            op3         <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX4_PARITY_EN
            par_err     <= 1'b0;
`endif
            for (int unsigned i = 0; i < NSH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX4_PARITY_EN
            par_err     <= 1'b0;
`endif
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            shadow[0] <= din;
                            slot      <= 3'd1;
                            state     <= LOCKED;
                            locked    <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        // Realign takes priority, including over the final-slot update.
                        if (sync && slot != 3'd0) begin
                            sync_err  <= 1'b1;
                            shadow[0] <= din;
                            slot      <= 3'd1;
                        end else if (!sync && slot == 3'd0) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end else if (slot == LAST) begin
                            slot <= '0;
`ifdef TDM_DEMUX4_PARITY_EN
                            if (par_ok) begin
                                op0         <= shadow[0];
                                op1         <= shadow[1];
                                op2         <= shadow[2];
                                op3         <= shadow[3];
                                frame_valid <= 1'b1;
                            end else begin
                                par_err <= 1'b1;
                            end
`else
                            op0         <= shadow[0];
                            op1         <= shadow[1];
                            op2         <= shadow[2];
                            op3         <= din;
                            frame_valid <= 1'b1;
`endif
                        end else begin
                            for (int unsigned i = 0; i < NSH; i++) begin
                                if (slot == 3'(i)) begin
                                    shadow[i] <= din;
                                end
                            end
                            slot <= 3'(slot + 3'd1);
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=4); parity build selected by TDM_DEMUX4_PARITY_EN.
module tb_tdm_demux4;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       din_valid;
    logic       sync;
    logic [3:0] op0, op1, op2, op3;
    logic       frame_valid, locked, sync_err, par_err;

    int vectors = 0;
    int miscompares = 0;

    tdm_demux4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .op0         (op0),
        .op1         (op1),
        .op2         (op2),
        .op3         (op3),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .par_err     (par_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic s, input logic [3:0] d);
        din_valid = 1'b1;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lanes();
        return {16'h0, op0, op1, op2, op3};
    endfunction

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sync      = 1'b0;
        idle(3);
        chk("reset_ops", lanes(), 32'h0000);
        chk("reset_flags", {28'h0, frame_valid, locked, sync_err, par_err}, 32'h0);
        rst_n = 1'b1;
        idle(1);

`ifndef TDM_DEMUX4_PARITY_EN
        // clean frame 1,0,1,1
        beat(1'b1, 4'h1);
        chk("lock_on_sync", {31'h0, locked}, 32'h1);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'h1);
        chk("no_early_fv", {31'h0, frame_valid}, 32'h0);
        beat(1'b0, 4'h1);
        chk("frame1_ops", lanes(), 32'h1011);
        chk("frame1_fv", {30'h0, frame_valid, sync_err}, 32'h2);
        idle(1);
        chk("fv_one_cycle", {31'h0, frame_valid}, 32'h0);

        // missing sync on slot 0 drops to HUNT
        beat(1'b0, 4'h9);
        chk("nosync_err", {30'h0, sync_err, locked}, 32'h2);
        beat(1'b0, 4'h9);
        beat(1'b0, 4'h9);
        beat(1'b0, 4'h9);
        chk("hunt_discard", {30'h0, sync_err, locked}, 32'h0);
        chk("hunt_ops_hold", lanes(), 32'h1011);
        beat(1'b1, 4'h5);
        chk("relock", {31'h0, locked}, 32'h1);
        beat(1'b0, 4'ha);
        beat(1'b0, 4'h3);
        beat(1'b0, 4'hc);
        chk("frame2_ops", lanes(), 32'h5a3c);

        // early sync at slot 2
        beat(1'b1, 4'h7);
        beat(1'b0, 4'h8);
        beat(1'b1, 4'h2);
        chk("realign_err", {29'h0, frame_valid, locked, sync_err}, 32'h3);
        chk("realign_hold", lanes(), 32'h5a3c);
        beat(1'b0, 4'h4);
        chk("realign_err_once", {31'h0, sync_err}, 32'h0);
        beat(1'b0, 4'h6);
        beat(1'b0, 4'he);
        chk("frame3_ops", lanes(), 32'h246e);

        // sync on the final slot: realign wins
        beat(1'b1, 4'h1);
        beat(1'b0, 4'h2);
        beat(1'b0, 4'h3);
        beat(1'b1, 4'hf);
        chk("final_realign", {30'h0, frame_valid, sync_err}, 32'h1);
        chk("final_hold", lanes(), 32'h246e);
        beat(1'b0, 4'hd);
        beat(1'b0, 4'hb);
        beat(1'b0, 4'h9);
        chk("frame4_ops", lanes(), 32'hfdb9);
        chk("frame4_fv", {31'h0, frame_valid}, 32'h1);

        // back-to-back frame with a 5-cycle gap between slots 1 and 2
        beat(1'b1, 4'h3);
        chk("b2b_fv_low", {31'h0, frame_valid}, 32'h0);
        beat(1'b0, 4'h6);
        idle(5);
        chk("gap_hold", {29'h0, frame_valid, locked, sync_err}, 32'h2);
        beat(1'b0, 4'h9);
        beat(1'b0, 4'hc);
        chk("gap_frame_ops", lanes(), 32'h369c);
        chk("gap_frame_fv", {31'h0, frame_valid}, 32'h1);

        // asynchronous reset at slot 2
        beat(1'b1, 4'h1);
        beat(1'b0, 4'h2);
        din_valid = 1'b1;
        din       = 4'h4;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ops", lanes(), 32'h0000);
        chk("async_rst_flags", {28'h0, frame_valid, locked, sync_err, par_err}, 32'h0);
        din_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        beat(1'b1, 4'h8);
        beat(1'b0, 4'h4);
        beat(1'b0, 4'h2);
        beat(1'b0, 4'h1);
        chk("post_rst_ops", lanes(), 32'h8421);
        chk("post_rst_fv", {31'h0, frame_valid}, 32'h1);
        chk("par_err_tied", {31'h0, par_err}, 32'h0);
`else
        // good parity: 1^1^0^1 = 1
        beat(1'b1, 4'h1);
        beat(1'b0, 4'h1);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'h1);
        chk("par_no_fv_slot3", {31'h0, frame_valid}, 32'h0);
        beat(1'b0, 4'h1);
        chk("par_ok_ops", lanes(), 32'h1101);
        chk("par_ok_flags", {29'h0, frame_valid, par_err, locked}, 32'h5);
        // same frame, parity bit 0
        beat(1'b1, 4'h1);
        beat(1'b0, 4'h1);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'h1);
        beat(1'b0, 4'h0);
        chk("par_bad_flags", {29'h0, frame_valid, par_err, locked}, 32'h3);
        idle(1);
        chk("par_err_pulse", {31'h0, par_err}, 32'h0);
        // different data, wrong parity: outputs must hold
        beat(1'b1, 4'h2);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'he);
        chk("par_bad_hold", lanes(), 32'h1101);
        chk("par_bad2_err", {31'h0, par_err}, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
